// File: rtl/therm_pkg.sv
// Shared constants, state encoding and thermometer helper for the
// therm_encode_arbiter slice.
package therm_pkg;

  localparam int N_REQ   = 4;
  localparam int VAL_W   = 3;
  localparam int THERM_W = 7;
  localparam int ID_W    = 2;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_ENC  = 1'b1
  } state_t;

  // Bit i of the code is set when the value exceeds i.
  function automatic logic [THERM_W-1:0] therm_of(input logic [VAL_W-1:0] v);
    logic [THERM_W-1:0] t;
    t = '0;
    for (int i = 0; i < THERM_W; i++) begin
      t[i] = (i < int'(v));
    end
    return t;
  endfunction

endpackage

// File: rtl/therm_gray_encode.sv
// Shared combinational datapath: 3-bit value to thermometer code and gated
// Gray code.
module therm_gray_encode
  import therm_pkg::*;
(
  input  logic [VAL_W-1:0]   value,
  input  logic               enable,
  output logic [THERM_W-1:0] therm,
  output logic [VAL_W-1:0]   gray
);

  assign therm = therm_of(value);
  assign gray  = enable ? (value ^ (value >> 1)) : '0;

endmodule

// File: rtl/therm_encode_arbiter.sv
// Round-robin arbiter feeding four requesters through one shared encoder,
// with registered, ID-tagged results.
module therm_encode_arbiter
  import therm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*VAL_W-1:0] value,
  input  logic                   enable,
  output logic [N_REQ-1:0]       ack,
  output logic                   busy,
  output logic                   out_valid,
  output logic [ID_W-1:0]        out_id,
  output logic [THERM_W-1:0]     out_therm,
  output logic [VAL_W-1:0]       out_gray
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_id;
  logic [VAL_W-1:0]     r_val;
  logic [N_REQ-1:0]     r_ack;
  logic                 r_valid;
  logic [ID_W-1:0]      r_out_id;
  logic [THERM_W-1:0]   r_out_therm;
  logic [VAL_W-1:0]     r_out_gray;
  logic [ID_W-1:0]      w_grant;
  logic                 w_found;
  logic [THERM_W-1:0]   w_therm;
  logic [VAL_W-1:0]     w_gray;

  // Search upward from the pointer; the 2-bit sum wraps modulo N_REQ.
  always_comb begin
    w_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && req[r_ptr + ID_W'(i)]) begin
        w_grant = r_ptr + ID_W'(i);
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ENC;
      S_ENC:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  therm_gray_encode u_enc (
    .value  (r_val),
    .enable (enable),
    .therm  (w_therm),
    .gray   (w_gray)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_id        <= '0;
      r_val       <= '0;
      r_ack       <= '0;
      r_valid     <= 1'b0;
      r_out_id    <= '0;
      r_out_therm <= '0;
      r_out_gray  <= '0;
    end else begin
      r_ack   <= '0;
      r_valid <= 1'b0;
      if (r_state == S_IDLE && w_found) begin
        r_ack <= {{(N_REQ-1){1'b0}}, 1'b1} << w_grant;
        r_id  <= w_grant;
        r_val <= value[w_grant*VAL_W +: VAL_W];
        r_ptr <= w_grant + 1'b1;
      end
      if (r_state == S_ENC) begin
        r_valid     <= 1'b1;
        r_out_id    <= r_id;
        r_out_therm <= w_therm;
        r_out_gray  <= w_gray;
      end
    end
  end

  assign ack       = r_ack;
  assign busy      = (r_state == S_ENC);
  assign out_valid = r_valid;
  assign out_id    = r_out_id;
  assign out_therm = r_out_therm;
  assign out_gray  = r_out_gray;

endmodule

// File: tb/tb_therm_encode_arbiter.sv
// Randomized and directed bench for therm_encode_arbiter against a
// transaction-level reference model.
module tb_therm_encode_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [11:0] value;
  logic        enable;
  logic [3:0]  ack;
  logic        busy;
  logic        out_valid;
  logic [1:0]  out_id;
  logic [6:0]  out_therm;
  logic [2:0]  out_gray;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int m_ptr, m_id, m_val;
  bit m_enc;
  int e_ack, e_busy, e_valid, e_id, e_therm, e_gray;

  therm_encode_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .value     (value),
    .enable    (enable),
    .ack       (ack),
    .busy      (busy),
    .out_valid (out_valid),
    .out_id    (out_id),
    .out_therm (out_therm),
    .out_gray  (out_gray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_id = 0; m_val = 0; m_enc = 0;
    e_ack = 0; e_busy = 0; e_valid = 0; e_id = 0; e_therm = 0; e_gray = 0;
  endtask

  task automatic model_edge();
    bit found;
    int g;
    e_ack   = 0;
    e_valid = 0;
    if (m_enc) begin
      e_valid = 1;
      e_id    = m_id;
      e_therm = (1 << m_val) - 1;
      e_gray  = enable ? (m_val ^ (m_val >> 1)) : 0;
      m_enc   = 0;
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        g = (m_ptr + k) % 4;
        if (!found && req[g]) begin
          found = 1;
          m_id  = g;
          m_val = int'((value >> (g * 3)) & 12'h7);
          e_ack = 1 << g;
          m_ptr = (g + 1) % 4;
          m_enc = 1;
        end
      end
    end
    e_busy = m_enc;
  endtask

  task automatic compare_all();
    chk("ack",       ack,       e_ack);
    chk("busy",      busy,      e_busy);
    chk("out_valid", out_valid, e_valid);
    chk("out_id",    out_id,    e_id);
    chk("out_therm", out_therm, e_therm);
    chk("out_gray",  out_gray,  e_gray);
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 1'b0;
  endtask

  task automatic set_val(input int i, input int v);
    value[i*3 +: 3] = 3'(v);
  endtask

  logic [6:0] exp_t [4] = '{7'b0000000, 7'b0000111, 7'b0111111, 7'b1111111};
  logic [2:0] exp_g [4] = '{3'b000, 3'b010, 3'b101, 3'b100};

  initial begin
    clk = 1'b0; rst = 1'b1; req = '0; value = '0; enable = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // single request, value 5
    req = 4'b0001; set_val(0, 5); enable = 1'b1;
    step();
    chk("t1_ack", ack, 4'b0001);
    req = 4'b0000;
    step();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_id",    out_id,    2'd0);
    chk("t1_therm", out_therm, 7'b0011111);
    chk("t1_gray",  out_gray,  3'b111);

    // all four held high: strict rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111; set_val(0, 0); set_val(1, 3); set_val(2, 6); set_val(3, 7); enable = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("t2_ack", ack, 4'b0001 << (n % 4));
      step();
      chk("t2_id",    out_id,    n % 4);
      chk("t2_therm", out_therm, exp_t[n%4]);
      chk("t2_gray",  out_gray,  exp_g[n%4]);
    end
    req = 4'b0000;

    // enable low gates Gray only
    do_reset();
    req = 4'b0100; set_val(2, 4); enable = 1'b0;
    step();
    req = 4'b0000;
    step();
    chk("t3_therm", out_therm, 7'b0001111);
    chk("t3_gray",  out_gray,  3'b000);

    // pointer wraps after grant to requester 3
    do_reset();
    req = 4'b1000;
    step();
    chk("t4_ack3", ack, 4'b1000);
    req = 4'b0000;
    step();
    req = 4'b1001;
    step();
    chk("t4_wrap", ack, 4'b0001);
    req = 4'b0000;
    step();

    // reset while ENC drops the grant in flight
    do_reset();
    req = 4'b0010; enable = 1'b1;
    step();
    chk("t5_ack", ack, 4'b0010);
    req = 4'b0000;
    do_reset();
    step();
    chk("t5_novalid", out_valid, 1'b0);
    req = 4'b0010;
    step();
    chk("t5_regrant", ack, 4'b0010);
    req = 4'b0000;
    step();
    chk("t5_valid", out_valid, 1'b1);
    chk("t5_id",    out_id,    2'd1);

    // value change in the ack cycle must not reach the result
    do_reset();
    req = 4'b0010; set_val(1, 2); enable = 1'b1;
    step();
    set_val(1, 7); req = 4'b0000;
    step();
    chk("t6_therm", out_therm, 7'b0000011);
    chk("t6_gray",  out_gray,  3'b011);

    // random traffic with occasional resets
    for (int c = 0; c < 600; c++) begin
      req    = 4'($urandom_range(0, 15));
      value  = 12'($urandom);
      enable = 1'($urandom);
      if ($urandom_range(0, 60) == 0) do_reset();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/therm_encode_arbiter.md
# therm_encode_arbiter

Round-robin arbiter and sequencer that shares one 3-bit-to-thermometer/Gray encoding datapath among four requesters. Each requester presents a 3-bit decimal value (0..7) and raises a request. The block grants one requester at a time, latches its value and drives the shared encoder. It then returns a registered 7-bit thermometer code and 3-bit Gray code tagged with the requester ID. It sits between the value producers and the display/compare logic that consumes encoded codes.

## Interface
Parameters:
- N_REQ, 4, number of requesters (ID width fixed at 2 bits; only 4 is supported)
- VAL_W, 3, width of each decimal value
- THERM_W, 7, thermometer width, equals 2**VAL_W - 1

Ports:
- clk  input  1  single clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  N_REQ  per-requester request level; bit i belongs to requester i
- value  input  N_REQ*VAL_W  requester i value at bits [i*VAL_W +: VAL_W]
- enable  input  1  Gray output enable, sampled in the ENC cycle
- ack  output  N_REQ  one-hot, one-cycle grant acknowledge
- busy  output  1  high while the state is ENC
- out_valid  output  1  one-cycle pulse marking a new result
- out_id  output  2  ID of the requester for the current result
- out_therm  output  THERM_W  thermometer code: the low `value` bits are 1
- out_gray  output  VAL_W  value ^ (value >> 1) when enable=1, else 0

## Operation
- FSM, two states:
  - IDLE: sample req. If no bit is set, stay in IDLE. Otherwise pick the grant g, latch value[g] and g, pulse ack[g], and go to ENC.
  - ENC: register the encoder outputs into out_therm, out_gray and out_id, set out_valid, then return to IDLE. In ENC, req is ignored.
- Round-robin search:
  - The pointer resets to 0.
  - The search starts at the pointer and runs upward modulo N_REQ; the first set bit wins.
  - After a grant to g, the pointer becomes (g+1) mod N_REQ.
- Thermometer mapping: 0→0000000, 1→0000001, …, 7→1111111.
- Gray is computed from the latched value, not from out_therm.
- Requester rule:
  - Hold req and value stable until ack is seen.
  - Deassert req in the cycle after ack, or keep it high to make a new request.
  - A req still high in the next IDLE cycle is treated as a new request.
- Changes to value after ack have no effect on the result in flight.
- out_therm, out_gray and out_id hold their last value between out_valid pulses.

## Timing
- Reset: ack=0, out_valid=0, busy=0, out_id=0, out_therm=0, out_gray=0, pointer=0, state=IDLE. All of these apply immediately on rst.
- Latency: for a req sampled high in IDLE at edge k:
  - ack high in cycle k+1, together with busy.
  - out_valid and the result appear in cycle k+2.
- Throughput: at most one grant every 2 cycles.
- out_valid and the next ack never coincide. The earliest next ack is in the same cycle as out_valid? No: after out_valid in cycle k+2 (state IDLE), the next ack appears in cycle k+3.
- Simultaneous requests: exactly one ack bit per grant. No requester is starved; worst-case wait is N_REQ grants.
- enable is sampled only in ENC. Toggling it at other times has no effect on the result.
- Reset mid-ENC: the grant in flight is dropped, with no out_valid. The pointer returns to 0.

## Structure
- Shared package/include `therm_pkg`:
  - N_REQ, VAL_W, THERM_W
  - state encodings S_IDLE=1'b0, S_ENC=1'b1
- One combinational sub-module, `therm_gray_encode`:
  - inputs: value [VAL_W], enable
  - outputs: therm [THERM_W], gray [VAL_W]
  - instantiated once as the shared datapath.
- The arbiter, pointer, FSM and output registers live in the top module.

## Test plan
- Reset, then req=0001 with value0=5 and enable=1: ack=0001 in cycle 1; in cycle 2, out_valid=1, out_id=0, out_therm=0011111, out_gray=111.
- req=1111 held continuously with values 0,3,6,7: grants arrive in order 0,1,2,3,0 every 2 cycles. Therm outputs are 0000000, 0000111, 0111111, 1111111; Gray outputs are 000, 010, 101, 100.
- req=0100 with value2=4 and enable=0: out_therm=0001111 and out_gray=000.
- After a grant to requester 3, raise req=1001: the next ack is 0001, because the pointer wrapped to 0.
- Assert rst during ENC after ack=0010: no out_valid follows, all outputs are 0, and a following req=0010 is granted normally.
- Change value1 from 2 to 7 in the ack cycle: the result is still out_therm=0000011 and out_gray=011.
